// File: rtl/fetch_unit.sv
// Instruction-fetch stage: program counter, byte-addressed instruction store and
// the F/D pipeline register, with stall/redirect handling and sticky fault detection.
module fetch_unit #(
    parameter int          IMEM_BYTES = 128,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD   = 32'h0000_0020
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic [31:0] FD_PC,
    output logic [31:0] FD_IR,
    output logic        FD_valid,
    output logic        pc_fault
);

    localparam int AW = $clog2(IMEM_BYTES);

    // Indexed by byte address; contents are preloaded from outside, never written here.
    logic [31:0] instruction [IMEM_BYTES];

    logic [31:0] PC;
    logic [31:0] pc_d;
    logic [31:0] fd_pc_q,    fd_pc_d;
    logic [31:0] fd_ir_q,    fd_ir_d;
    logic        fd_valid_q, fd_valid_d;
    logic        fault_q,    fault_d;

    logic        fetch_legal;
    logic [31:0] fetch_word;

    // No masking of the PC: a wrapped or out-of-range value must fail this check.
    assign fetch_legal = (PC < 32'(IMEM_BYTES)) && (PC[1:0] == 2'b00);
    assign fetch_word  = instruction[PC[AW-1:0]];

    always_comb begin
        pc_d       = PC;
        fd_pc_d    = fd_pc_q;
        fd_ir_d    = fd_ir_q;
        fd_valid_d = fd_valid_q;
        fault_d    = fault_q;
        if (redirect_valid) begin
            // Squash the wrong-path fetch; the target is validated when it is fetched.
            pc_d       = redirect_target;
            fd_pc_d    = PC;
            fd_ir_d    = NOP_WORD;
            fd_valid_d = 1'b0;
        end else if (!stall) begin
            if (!fetch_legal) begin
                fd_pc_d    = PC;
                fd_ir_d    = NOP_WORD;
                fd_valid_d = 1'b0;
                fault_d    = 1'b1;
            end else begin
                fd_pc_d    = PC;
                fd_ir_d    = fetch_word;
                fd_valid_d = 1'b1;
                pc_d       = PC + 32'd4;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            PC         <= RESET_PC;
            fd_pc_q    <= 32'd0;
            fd_ir_q    <= NOP_WORD;
            fd_valid_q <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            PC         <= pc_d;
            fd_pc_q    <= fd_pc_d;
            fd_ir_q    <= fd_ir_d;
            fd_valid_q <= fd_valid_d;
            fault_q    <= fault_d;
        end
    end

    assign FD_PC    = fd_pc_q;
    assign FD_IR    = fd_ir_q;
    assign FD_valid = fd_valid_q;
    assign pc_fault = fault_q;

endmodule
